// File: rtl/scalar_wb_sink.sv
// Register file with scoreboard and a sink for writeback-stage results.
// Latency: reads and bypass are combinational; scoreboard, data and status take effect at the next CLK edge.
// Backpressure: iss_stall refuses a reservation of a still-busy register (WAW) unless it is being written back this cycle.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   wb_valid/reg/data    writeback result to commit and to un-reserve
//   iss_valid/rd         reservation request for a destination register
//   iss_stall            reservation refused this cycle
//   rsN_sel/data/busy    two combinational read ports with writeback bypass
//   busy_vec             registered scoreboard bits (bit 0 always 0)
//   wb_spurious          one-cycle pulse: last writeback hit a non-busy register
//   wb_count             saturating count of accepted writebacks
module scalar_wb_sink #(
    parameter int NUM_REGS = 32,
    parameter int WORD_W   = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                wb_valid,
    input  logic [4:0]          wb_reg,
    input  logic [WORD_W-1:0]   wb_data,
    input  logic                iss_valid,
    input  logic [4:0]          iss_rd,
    output logic                iss_stall,
    input  logic [4:0]          rs1_sel,
    input  logic [4:0]          rs2_sel,
    output logic [WORD_W-1:0]   rs1_data,
    output logic [WORD_W-1:0]   rs2_data,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                wb_spurious,
    output logic [15:0]         wb_count
);

    typedef logic [4:0]        regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    word_t               r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic                r_spurious;
    logic [15:0]         r_count;

    logic                w_wb_hit;
    logic                w_iss_set;
    logic                w_stall;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Inputs are ignored while reset is asserted, so the bypass path also
    // reads as zero during reset.
    assign w_wb_hit  = nRST && wb_valid && (wb_reg != regbits_t'(0));

    // A busy destination may be re-reserved only when its pending result
    // lands in the same cycle.
    assign w_stall   = nRST && iss_valid && (iss_rd != regbits_t'(0)) && r_busy[iss_rd]
                       && !(wb_valid && (wb_reg == iss_rd));
    assign w_iss_set = nRST && iss_valid && (iss_rd != regbits_t'(0)) && !w_stall;

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb_hit)  w_busy_nxt[wb_reg] = 1'b0;
        // Set after clear: a same-cycle writeback and re-reservation stays busy.
        if (w_iss_set) w_busy_nxt[iss_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        rs1_data = '0;
        rs1_busy = 1'b0;
        if (rs1_sel != regbits_t'(0)) begin
            if (w_wb_hit && (wb_reg == rs1_sel)) begin
                rs1_data = wb_data;
            end else begin
                rs1_data = r_regs[rs1_sel];
                rs1_busy = r_busy[rs1_sel];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        rs2_busy = 1'b0;
        if (rs2_sel != regbits_t'(0)) begin
            if (w_wb_hit && (wb_reg == rs2_sel)) begin
                rs2_data = wb_data;
            end else begin
                rs2_data = r_regs[rs2_sel];
                rs2_busy = r_busy[rs2_sel];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_busy     <= '0;
            r_spurious <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_wb_hit) r_regs[wb_reg] <= wb_data;
            r_busy     <= w_busy_nxt;
            r_spurious <= w_wb_hit && !r_busy[wb_reg];
            if (w_wb_hit && (r_count != 16'hFFFF)) r_count <= r_count + 16'd1;
        end
    end

    assign iss_stall   = w_stall;
    assign busy_vec    = r_busy;
    assign wb_spurious = r_spurious;
    assign wb_count    = r_count;

endmodule

// File: tb/tb_scalar_wb_sink.sv
module tb_scalar_wb_sink;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_stall;
    logic [4:0]  rs1_sel, rs2_sel;
    logic [31:0] rs1_data, rs2_data;
    logic        rs1_busy, rs2_busy;
    logic [31:0] busy_vec;
    logic        wb_spurious;
    logic [15:0] wb_count;

    always #5 CLK = ~CLK;

    scalar_wb_sink #(.NUM_REGS(32), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy_vec(busy_vec), .wb_spurious(wb_spurious), .wb_count(wb_count)
    );

    // Behavioural model: architectural state as plain arrays and integers.
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic        m_spur;
    int          m_count;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'h0;
            m_busy[i] = 1'b0;
        end
        m_spur  = 1'b0;
        m_count = 0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] sel);
        if (sel == 5'd0) return 32'h0;
        if (wb_valid && wb_reg == sel) return wb_data;
        return m_regs[sel];
    endfunction

    function automatic logic exp_bz(input logic [4:0] sel);
        if (sel == 5'd0) return 1'b0;
        if (wb_valid && wb_reg == sel) return 1'b0;
        return m_busy[sel];
    endfunction

    function automatic logic exp_stall();
        return iss_valid && iss_rd != 5'd0 && m_busy[iss_rd] && !(wb_valid && wb_reg == iss_rd);
    endfunction

    function automatic logic [31:0] model_busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Settle combinational outputs and compare them against the model.
    task automatic settle();
        #1;
        chk("rs1_data", rs1_data, exp_rd(rs1_sel));
        chk("rs2_data", rs2_data, exp_rd(rs2_sel));
        chk("rs1_busy", 32'(rs1_busy), 32'(exp_bz(rs1_sel)));
        chk("rs2_busy", 32'(rs2_busy), 32'(exp_bz(rs2_sel)));
        chk("iss_stall", 32'(iss_stall), 32'(exp_stall()));
    endtask

    // Advance one edge, apply the rules to the model, compare registered outputs.
    task automatic clk_step();
        logic hit, set;
        @(posedge CLK);
        hit = wb_valid && wb_reg != 5'd0;
        set = iss_valid && iss_rd != 5'd0 && !exp_stall();
        m_spur = hit && !m_busy[wb_reg];
        if (hit) begin
            m_regs[wb_reg] = wb_data;
            m_busy[wb_reg] = 1'b0;
            if (m_count < 65535) m_count++;
        end
        if (set) m_busy[iss_rd] = 1'b1;
        #1;
        chk("busy_vec", busy_vec, model_busy_vec());
        chk("wb_spurious", 32'(wb_spurious), 32'(m_spur));
        chk("wb_count", 32'(wb_count), 32'(m_count));
    endtask

    task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ir,
                         input logic [4:0] s1, input logic [4:0] s2);
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        iss_valid = iv; iss_rd = ir; rs1_sel = s1; rs2_sel = s2;
    endtask

    task automatic rand_cycle(input bit narrow);
        logic [4:0] lim;
        lim = narrow ? 5'd7 : 5'd31;
        drive(($urandom_range(0, 2) != 0), 5'($urandom_range(0, int'(lim))), $urandom,
              ($urandom_range(0, 1) != 0), 5'($urandom_range(0, int'(lim))),
              5'($urandom_range(0, int'(lim))), 5'($urandom_range(0, 31)));
        settle();
        clk_step();
    endtask

    initial begin
        nRST = 1'b0;
        drive(1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd4, 5'd4, 5'd0);
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("reset busy_vec", busy_vec, 32'h0);
        chk("reset wb_count", 32'(wb_count), 32'h0);
        chk("reset wb_spurious", 32'(wb_spurious), 32'h0);
        chk("reset rs1_data", rs1_data, 32'h0);
        nRST = 1'b1;

        // Reserve r5, then see it busy on the read port.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 5'd0);
        settle(); clk_step();
        chk("r5 reserved", 32'(busy_vec[5]), 32'h1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
        settle();
        chk("rs1_busy r5", 32'(rs1_busy), 32'h1);
        clk_step();

        // Writeback r5 with same-cycle bypass.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5);
        settle();
        chk("bypass data", rs1_data, 32'hDEADBEEF);
        chk("bypass busy", 32'(rs1_busy), 32'h0);
        clk_step();
        chk("r5 cleared", 32'(busy_vec[5]), 32'h0);
        chk("wb_count one", 32'(wb_count), 32'h1);

        // WAW hazard on r7, resolved by same-cycle writeback.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0);
        settle(); clk_step();
        settle();
        chk("waw stall", 32'(iss_stall), 32'h1);
        clk_step();
        chk("r7 still busy", 32'(busy_vec[7]), 32'h1);
        drive(1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 5'd0, 5'd0);
        settle();
        chk("waw resolved", 32'(iss_stall), 32'h0);
        clk_step();
        chk("set wins", 32'(busy_vec[7]), 32'h1);
        chk("no spurious r7", 32'(wb_spurious), 32'h0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
        settle();
        chk("r7 data", rs1_data, 32'h1234_5678);
        clk_step();

        // r0 is hardwired.
        drive(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 5'd0, 5'd0);
        settle();
        chk("r0 read", rs1_data, 32'h0);
        chk("r0 stall", 32'(iss_stall), 32'h0);
        clk_step();
        chk("r0 busy", 32'(busy_vec[0]), 32'h0);
        chk("r0 count", 32'(wb_count), 32'h2);
        chk("busy after r0", busy_vec, 32'h0000_0080);

        // Writeback to a non-busy register.
        drive(1'b1, 5'd9, 32'h0000_A5A5, 1'b0, 5'd0, 5'd0, 5'd0);
        settle(); clk_step();
        chk("spurious pulse", 32'(wb_spurious), 32'h1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0);
        settle();
        chk("r9 data", rs1_data, 32'h0000_A5A5);
        clk_step();
        chk("spurious one cycle", 32'(wb_spurious), 32'h0);

        // Random traffic, first concentrated on few registers for hazards.
        for (int i = 0; i < 1500; i++) rand_cycle(1'b1);
        for (int i = 0; i < 1500; i++) rand_cycle(1'b0);

        // Saturation: 65540 consecutive accepted writebacks.
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom, ($urandom_range(0, 1) != 0),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            settle();
            clk_step();
        end
        chk("saturated", 32'(wb_count), 32'h0000_FFFF);

        // Asynchronous reset between edges, with inputs still active.
        drive(1'b1, 5'd3, 32'hCAFE_F00D, 1'b1, 5'd3, 5'd3, 5'd5);
        #2;
        nRST = 1'b0;
        #1;
        chk("arst busy_vec", busy_vec, 32'h0);
        chk("arst wb_count", 32'(wb_count), 32'h0);
        chk("arst wb_spurious", 32'(wb_spurious), 32'h0);
        chk("arst rs1_data", rs1_data, 32'h0);
        chk("arst rs2_data", rs2_data, 32'h0);
        chk("arst rs1_busy", 32'(rs1_busy), 32'h0);
        chk("arst iss_stall", 32'(iss_stall), 32'h0);
        @(posedge CLK);
        #1;
        chk("held busy_vec", busy_vec, 32'h0);
        chk("held wb_count", 32'(wb_count), 32'h0);
        model_reset();
        nRST = 1'b1;

        for (int i = 0; i < 500; i++) rand_cycle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
